// File: rtl/config_pkg.sv
// Project-wide elaborated configuration shared by the front-end blocks.
package config_pkg;

  typedef struct packed {
    int unsigned FTQ_DEPTH;
    int unsigned VLEN;
  } cfg_t;

  localparam cfg_t DefaultCfg = '{FTQ_DEPTH: 8, VLEN: 32};

endpackage

// File: rtl/ftq_pkg.sv
// Fetch target queue helpers: entry sizing and wrap-bit pointer arithmetic.
package ftq_pkg;

  function automatic int unsigned entry_width(input int unsigned vlen);
    return 2 * vlen + 1;
  endfunction

  // Pointers carry an extra wrap bit, so they count modulo 2*depth.
  function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int unsigned ptrW);
    return (ptr + 32'd1) & ((32'd1 << ptrW) - 32'd1);
  endfunction

  function automatic logic [31:0] ptr_dist(input logic [31:0] a, input logic [31:0] b,
                                           input int unsigned ptrW);
    return (a - b) & ((32'd1 << ptrW) - 32'd1);
  endfunction

endpackage

// File: rtl/ftq.sv
// Fetch Target Queue: buffers predicted fetch blocks between the BPU and IFU
// and keeps them addressable by index until the backend commits them.
module ftq
  import ftq_pkg::*;
#(
  parameter config_pkg::cfg_t Cfg = config_pkg::DefaultCfg,
  localparam int unsigned DEPTH = Cfg.FTQ_DEPTH,
  localparam int unsigned VLEN  = Cfg.VLEN,
  localparam int unsigned IDX_W = $clog2(DEPTH),
  localparam int unsigned PTR_W = IDX_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             bpu_valid_i,
  output logic             bpu_ready_o,
  input  logic [VLEN-1:0]  bpu_start_pc_i,
  input  logic             bpu_pred_taken_i,
  input  logic [VLEN-1:0]  bpu_pred_target_i,
  output logic             ifu_valid_o,
  input  logic             ifu_ready_i,
  output logic [VLEN-1:0]  ifu_start_pc_o,
  output logic [IDX_W-1:0] ifu_ftq_idx_o,
  input  logic             commit_valid_i,
  input  logic             flush_i,
  input  logic [IDX_W-1:0] flush_idx_i,
  input  logic [IDX_W-1:0] query_idx_i,
  output logic [VLEN-1:0]  query_pc_o,
  output logic [VLEN-1:0]  query_target_o,
  output logic [PTR_W-1:0] count_o
);

  typedef struct packed {
    logic [VLEN-1:0] start_pc;
    logic            pred_taken;
    logic [VLEN-1:0] pred_target;
  } ftq_entry_t;

  typedef struct packed {
    logic             wrap;
    logic [IDX_W-1:0] idx;
  } ftq_ptr_t;

  ftq_entry_t       r_entries [DEPTH];
  ftq_ptr_t         r_enqPtr, r_fetchPtr, r_commitPtr;
  ftq_ptr_t         w_enqNext, w_fetchNext, w_commitNext, w_keep;
  logic             w_full, w_enq, w_fetch, w_commit, w_fetchBeyond;
  logic [IDX_W-1:0] w_flushOff;

  assign w_full      = (r_enqPtr.idx == r_commitPtr.idx) && (r_enqPtr.wrap != r_commitPtr.wrap);
  assign bpu_ready_o = !w_full && !flush_i;
  assign ifu_valid_o = (r_fetchPtr != r_enqPtr) && !flush_i;

  assign w_enq    = bpu_valid_i && bpu_ready_o;
  assign w_fetch  = ifu_valid_o && ifu_ready_i;
  assign w_commit = commit_valid_i && (r_commitPtr != r_fetchPtr);

  // The flush index is taken relative to the oldest live entry, then one past it.
  assign w_flushOff    = flush_idx_i - r_commitPtr.idx;
  assign w_keep        = PTR_W'(ptr_inc(32'(r_commitPtr) + 32'(w_flushOff), PTR_W));
  assign w_fetchBeyond = ptr_dist(32'(r_fetchPtr), 32'(r_commitPtr), PTR_W)
                       > ptr_dist(32'(w_keep), 32'(r_commitPtr), PTR_W);

  always_comb begin
    w_enqNext    = r_enqPtr;
    w_fetchNext  = r_fetchPtr;
    w_commitNext = r_commitPtr;
    if (flush_i) begin
      w_enqNext = w_keep;
      if (w_fetchBeyond) w_fetchNext = w_keep;
    end else begin
      if (w_enq)   w_enqNext   = PTR_W'(ptr_inc(32'(r_enqPtr), PTR_W));
      if (w_fetch) w_fetchNext = PTR_W'(ptr_inc(32'(r_fetchPtr), PTR_W));
    end
    if (w_commit) w_commitNext = PTR_W'(ptr_inc(32'(r_commitPtr), PTR_W));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_enqPtr    <= '0;
      r_fetchPtr  <= '0;
      r_commitPtr <= '0;
    end else begin
      r_enqPtr    <= w_enqNext;
      r_fetchPtr  <= w_fetchNext;
      r_commitPtr <= w_commitNext;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_entries[r_enqPtr.idx] <= '{start_pc:    bpu_start_pc_i,
                                   pred_taken:  bpu_pred_taken_i,
                                   pred_target: bpu_pred_target_i};
    end
  end

  assign ifu_start_pc_o = r_entries[r_fetchPtr.idx].start_pc;
  assign ifu_ftq_idx_o  = r_fetchPtr.idx;
  assign query_pc_o     = r_entries[query_idx_i].start_pc;
  assign query_target_o = r_entries[query_idx_i].pred_target;
  assign count_o        = PTR_W'(ptr_dist(32'(r_enqPtr), 32'(r_commitPtr), PTR_W));

  a_commitFetched: assert property (@(posedge clk_i) disable iff (!rst_ni)
    commit_valid_i |-> (r_commitPtr != r_fetchPtr));

  a_flushInRange: assert property (@(posedge clk_i) disable iff (!rst_ni)
    flush_i |-> ({1'b0, w_flushOff} < count_o));

endmodule

// File: doc/ftq.md
Name: ftq

Overview:
- Fetch Target Queue between the branch predictor (BPU) and the ICache fetch stage (IFU).
- Buffers predicted fetch blocks (start PC, predicted-taken flag, predicted target) in a circular queue.
- Issues each block to the IFU in order and holds it until the backend commits it, so redirects and PC lookups can reference entries by FTQ index.
- Sized entirely from the elaborated config (Cfg.FTQ_DEPTH, Cfg.VLEN).

Parameters:
- Cfg, config_pkg::cfg_t, default = project default elaborated config. Uses FTQ_DEPTH (power of two, ≥2) and VLEN.
- Derived, not overridable: IDX_W = $clog2(Cfg.FTQ_DEPTH); PTR_W = IDX_W+1 (extra wrap bit).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- bpu_valid_i  in  1  BPU offers a fetch block
- bpu_ready_o  out  1  FTQ accepts it
- bpu_start_pc_i  in  VLEN  block start PC
- bpu_pred_taken_i  in  1  predicted taken
- bpu_pred_target_i  in  VLEN  predicted next PC
- ifu_valid_o  out  1  entry available for fetch
- ifu_ready_i  in  1  IFU takes the entry
- ifu_start_pc_o  out  VLEN  PC of entry at fetch_ptr
- ifu_ftq_idx_o  out  IDX_W  index of that entry
- commit_valid_i  in  1  backend retires the oldest entry
- flush_i  in  1  redirect; squash entries younger than flush_idx_i
- flush_idx_i  in  IDX_W  last entry kept
- query_idx_i  in  IDX_W  backend PC lookup index
- query_pc_o  out  VLEN  start PC of query_idx_i (combinational)
- query_target_o  out  VLEN  predicted target of query_idx_i
- count_o  out  PTR_W  live entries, enq_ptr−commit_ptr

Behaviour:
- State: three PTR_W pointers, commit_ptr ≤ fetch_ptr ≤ enq_ptr (modular), plus entry storage. Storage needs no reset.
- Reset (async, rst_ni=0): all pointers 0. bpu_ready_o=1, ifu_valid_o=0, count_o=0.
- full = (enq_ptr.idx == commit_ptr.idx) && (wrap bits differ). The queue stays full until commit frees a slot; no same-cycle bypass.
- bpu_ready_o = !full && !flush_i.
- Enqueue when bpu_valid_i && bpu_ready_o: write entry[enq_ptr.idx], then enq_ptr++.
- ifu_valid_o = (fetch_ptr != enq_ptr) && !flush_i. ifu_* outputs are read combinationally from entry[fetch_ptr.idx].
- Enqueue-to-ifu_valid latency is one cycle; there is no same-cycle pass-through.
- Fetch handshake: ifu_valid_o && ifu_ready_i, then fetch_ptr++. ifu_start_pc_o must stay stable while ifu_valid_o=1 and ifu_ready_i=0.
- Commit: commit_valid_i && (commit_ptr != fetch_ptr), then commit_ptr++.
- Commit with commit_ptr == fetch_ptr is ignored and fires an assertion (unfetched entry).
- Flush: keep = (flush_idx_i position relative to commit_ptr) + 1, computed as a PTR_W pointer.
  - enq_ptr := keep.
  - fetch_ptr := keep if fetch_ptr is beyond keep, else unchanged.
  - The entry at flush_idx_i is retained.
  - flush_idx_i must lie within [commit_ptr, enq_ptr); violation is an assertion failure.
- Priority within one cycle: flush > enqueue (the BPU beat is dropped, since ready=0) and flush > fetch handshake. Commit is applied concurrently with flush.
- Flush and commit in the same cycle with flush_idx_i == commit index: the entry commits, so keep == new commit_ptr and the queue becomes empty.
- Simultaneous enqueue, fetch and commit are all legal. count_o reflects registered pointers only.
- Wrap-around: pointers wrap modulo 2·FTQ_DEPTH. The wrap bit disambiguates full from empty.
- Reset asserted mid-operation clears all pointers immediately. Any pending handshake is lost.

Decomposition:
- ftq_pkg holds ftq_entry_t {start_pc, pred_taken, pred_target}, sized from Cfg via parameterized typedef or packed width functions.
- ftq_pkg also holds ftq_ptr_t (wrap bit + idx) and helper functions ptr_inc and ptr_dist.
- No sub-module is needed. Storage is a flop array inside ftq. Pointer logic stays inline.

Test Plan:
- Reset, then enqueue PC 0x8000_0000 (taken=0) → next cycle ifu_valid_o=1, ifu_start_pc_o=0x8000_0000, ifu_ftq_idx_o=0, count_o=1.
- DEPTH=8: enqueue 8 blocks without commit → bpu_ready_o=0 and count_o=8. One fetch and one commit → bpu_ready_o=1 the following cycle.
- Hold ifu_ready_i=0 for 5 cycles with 3 entries queued → ifu_start_pc_o unchanged. Then ifu_ready_i=1 → entries emerge in order idx 0,1,2.
- Fill 5 entries, fetch 4, then flush_i with flush_idx_i=1 → enq_ptr=2, fetch_ptr=2, count_o=2, ifu_valid_o=0. Entries idx 0 and 1 remain queryable.
- Stream 20 blocks with continuous fetch and commit → indices wrap 7→0 and the wrap bit toggles. query_pc_o(idx 3) returns the latest PC written at idx 3.
- Same cycle: flush_i (flush_idx_i=commit index), commit_valid_i and bpu_valid_i → BPU beat dropped, count_o=0 next cycle. Also assert rst_ni mid-stream → outputs return to reset values asynchronously.
